// File: rtl/monty_arb.sv
// Round-robin arbiter sharing one fixed-latency Montgomery reducer among NREQ requesters.
// Tracks issue tags alongside the reducer and strobes each result back to its owner.
module monty_arb #(
  parameter int unsigned LOGQ   = 32,
  parameter int unsigned LOGQH  = 19,
  parameter int unsigned NREQ   = 4,
  parameter int unsigned LAT    = 6,
  parameter int unsigned MAXOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*LOGQH-1:0]    req_qH,
  input  logic [NREQ*2*LOGQ-1:0]   req_C,
  output logic [LOGQH-1:0]         red_qH,
  output logic [2*LOGQ-1:0]        red_C,
  input  logic [LOGQ-1:0]          red_T,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [LOGQ-1:0]          rsp_T,
  output logic                     busy
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SW  = IDW + 1;
  localparam int unsigned CW  = $clog2(MAXOUT + 1);
  localparam int unsigned DW  = 2 * LOGQ;

  logic [IDW-1:0]   r_ptr;
  logic [CW-1:0]    r_cnt [NREQ];
  logic [LAT:0]     r_tag_v;
  logic [IDW-1:0]   r_tag_id [LAT+1];
  logic [DW-1:0]    r_red_C;
  logic [LOGQH-1:0] r_red_qH;

  logic [NREQ-1:0]  w_rsp;
  logic [NREQ-1:0]  w_elig;
  logic [NREQ-1:0]  w_gnt_oh;
  logic             w_gnt_any;
  logic [IDW-1:0]   w_gnt_id;
  logic [DW-1:0]    w_sel_C;
  logic [LOGQH-1:0] w_sel_qH;

  // Response strobe decoded from the last tag stage; squashed while in reset.
  always_comb begin
    w_rsp = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_rsp[i] = r_tag_v[LAT] && (r_tag_id[LAT] == IDW'(i)) && !rst;
    end
  end

  // A returning response frees a slot in the same cycle, so it counts toward eligibility.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = req_valid[i] && ((r_cnt[i] < CW'(MAXOUT)) || w_rsp[i]);
    end
  end

  // Round-robin search starting at r_ptr, wrapping modulo NREQ.
  always_comb begin
    logic [SW-1:0]  sum;
    logic [IDW-1:0] idx;
    w_gnt_oh  = '0;
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, r_ptr} + SW'(k);
      if (sum >= SW'(NREQ)) begin
        sum = sum - SW'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!w_gnt_any && w_elig[idx] && !rst) begin
        w_gnt_any     = 1'b1;
        w_gnt_id      = idx;
        w_gnt_oh[idx] = 1'b1;
      end
    end
  end

  // Operand select for the granted requester.
  always_comb begin
    w_sel_C  = '0;
    w_sel_qH = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_oh[i]) begin
        w_sel_C  = req_C[i*DW +: DW];
        w_sel_qH = req_qH[i*LOGQH +: LOGQH];
      end
    end
  end

  // Control state: pointer, tag valids and per-requester outstanding counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_tag_v <= '0;
      for (int i = 0; i < NREQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_tag_v <= {r_tag_v[LAT-1:0], w_gnt_any};
      if (w_gnt_any) begin
        r_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + IDW'(1);
      end
      for (int i = 0; i < NREQ; i++) begin
        case ({w_gnt_oh[i], w_rsp[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  // Datapath registers: issue stage and tag ids carry no reset.
  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_gnt_id;
    for (int s = 1; s <= LAT; s++) begin
      r_tag_id[s] <= r_tag_id[s-1];
    end
    if (w_gnt_any) begin
      r_red_C  <= w_sel_C;
      r_red_qH <= w_sel_qH;
    end
  end

  assign req_ready = w_gnt_oh;
  assign red_C     = r_red_C;
  assign red_qH    = r_red_qH;
  assign rsp_valid = w_rsp;
  assign rsp_T     = red_T;
  assign busy      = (|r_tag_v) && !rst;

endmodule
